// File: rtl/stepmania_pkg.sv
// stepmania_pkg: types and constants shared by the chart sequencer and the
// arrow scroller.
//   seq_state_t    - chart sequencer FSM states
//   CHART_LANE_*   - location of the 4-lane note mask inside a chart ROM word
//   CHART_END_BIT  - end-of-chart marker bit inside a chart ROM word
//   NUM_LANES      - number of arrow lanes on the playfield
package stepmania_pkg;

  localparam int NUM_LANES      = 4;
  localparam int CHART_LANE_LSB = 0;
  localparam int CHART_LANE_W   = 4;
  localparam int CHART_END_BIT  = 4;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    WAIT,
    DONE
  } seq_state_t;

  // A beat period of zero frames is meaningless; treat it as one frame.
  function automatic logic [7:0] beat_period(input logic [7:0] frames_per_row);
    return (frames_per_row == 8'd0) ? 8'd1 : frames_per_row;
  endfunction

endpackage

// File: rtl/frame_edge.sv
// frame_edge: registered rising-edge detector for the vertical-sync tick.
// Shared by the chart sequencer and the scroller so both see the same
// single-cycle frame_rise.
//   Clk        in  - system clock
//   reset_n    in  - asynchronous active-low reset
//   frame_clk  in  - frame tick, synchronous to Clk
//   frame_rise out - high for the one cycle in which frame_clk is first seen high
module frame_edge (
  input  logic Clk,
  input  logic reset_n,
  input  logic frame_clk,
  output logic frame_rise
);

  logic frame_clk_q;

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_clk_q <= 1'b0;
    end else begin
      frame_clk_q <= frame_clk;
    end
  end

  assign frame_rise = frame_clk & ~frame_clk_q;

endmodule

// File: rtl/chart_sequencer.sv
// chart_sequencer: step-chart playback engine feeding the arrow scroller.
// Walks a synchronous chart ROM one row per beat (P frames) and presents each
// row's lane mask on display_signal for exactly one frame.
//   Clk, reset_n           - clock, asynchronous active-low reset
//   frame_clk              - frame tick (edge-detected internally)
//   start / stop           - one-cycle playback control pulses (stop dominates)
//   frames_per_row         - beat period in frames, latched on start (0 => 1)
//   rom_addr / rom_data    - chart ROM port, 1-cycle read latency
//   display_signal         - lane spawn mask, changes only on a frame rise
//   busy / done / row_idx  - status: playing, chart finished, last issued row
// Build option: define CHART_LOOP_EN to loop the chart on end marker or
// address wrap instead of stopping in DONE.
module chart_sequencer
  import stepmania_pkg::*;
#(
  parameter int ROW_AW = 8
) (
  input  logic                 Clk,
  input  logic                 reset_n,
  input  logic                 frame_clk,
  input  logic                 start,
  input  logic                 stop,
  input  logic [7:0]           frames_per_row,
  output logic [ROW_AW-1:0]    rom_addr,
  input  logic [7:0]           rom_data,
  output logic [NUM_LANES-1:0] display_signal,
  output logic                 busy,
  output logic                 done,
  output logic [ROW_AW-1:0]    row_idx
);

  logic frame_rise;

  frame_edge u_frame_edge (
    .Clk        (Clk),
    .reset_n    (reset_n),
    .frame_clk  (frame_clk),
    .frame_rise (frame_rise)
  );

  seq_state_t               state_q,     state_d;
  logic [ROW_AW-1:0]        addr_q,      addr_d;
  logic [7:0]               frame_cnt_q, frame_cnt_d;
  logic [7:0]               period_q,    period_d;
  logic [CHART_LANE_W-1:0]  row_buf_q,   row_buf_d;
  logic [NUM_LANES-1:0]     display_q,   display_d;
  logic [ROW_AW-1:0]        row_idx_q,   row_idx_d;
  logic                     done_q,      done_d;
  logic                     busy_q,      busy_d;

  // Bits above the end marker carry no meaning for playback.
  logic unused_rom_bits;
  assign unused_rom_bits = ^rom_data[7:CHART_END_BIT+1];

  always_comb begin
    // NOTE: every next-state signal gets a hold default first so no path
    // through the case leaves it unassigned (which would infer a latch).
    state_d     = state_q;
    addr_d      = addr_q;
    frame_cnt_d = frame_cnt_q;
    period_d    = period_q;
    row_buf_d   = row_buf_q;
    display_d   = display_q;
    row_idx_d   = row_idx_q;
    done_d      = done_q;

    // A mask is held for one frame; an issue on the same rise overrides this.
    if (frame_rise) begin
      display_d = '0;
    end

    if (frame_rise && (state_q inside {FETCH, LOAD, WAIT})) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end

    case (state_q)
      FETCH: state_d = LOAD;

      LOAD: begin
        row_buf_d = rom_data[CHART_LANE_LSB +: CHART_LANE_W];
        if (rom_data[CHART_END_BIT]) begin
`ifdef CHART_LOOP_EN
          // Beat counting continues, so row 0 follows without an extra beat.
          addr_d  = '0;
          state_d = FETCH;
`else
          state_d = DONE;
          done_d  = 1'b1;
`endif
        end else begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        // >= rather than == keeps playback moving if a rise landed in
        // FETCH/LOAD right after start and pushed the count past P-1.
        if (frame_rise && (frame_cnt_q >= period_q - 8'd1)) begin
          display_d   = row_buf_q;
          row_idx_d   = addr_q;
          frame_cnt_d = '0;
          addr_d      = addr_q + 1'b1;  // wraps to 0 after the last row
          state_d     = FETCH;
`ifndef CHART_LOOP_EN
          if (addr_q == '1) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
`endif
        end
      end

      default: ;
    endcase

    if (start) begin
      state_d     = FETCH;
      addr_d      = '0;
      frame_cnt_d = '0;
      row_idx_d   = '0;
      period_d    = beat_period(frames_per_row);
      display_d   = '0;
      done_d      = 1'b0;
    end

    // stop is applied last so it wins over start and over an issue.
    if (stop) begin
      state_d   = IDLE;
      display_d = '0;
      done_d    = 1'b0;
    end

    busy_d = (state_d inside {FETCH, LOAD, WAIT});
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      frame_cnt_q <= '0;
      period_q    <= '0;
      row_buf_q   <= '0;
      display_q   <= '0;
      row_idx_q   <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed above, independent of statement order.
      state_q     <= state_d;
      addr_q      <= addr_d;
      frame_cnt_q <= frame_cnt_d;
      period_q    <= period_d;
      row_buf_q   <= row_buf_d;
      display_q   <= display_d;
      row_idx_q   <= row_idx_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign rom_addr       = addr_q;
  assign display_signal = display_q;
  assign row_idx        = row_idx_q;
  assign done           = done_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_chart_sequencer.sv
// tb_chart_sequencer: directed self-checking bench for chart_sequencer.
// Drives a behavioural chart ROM and frame ticks; expected values are
// hand-derived per scenario. Honours CHART_LOOP_EN for the wrap scenario.
module tb_chart_sequencer;

  logic       Clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       frame_clk = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] frames_per_row = 8'd0;
  logic [7:0] rom_addr;
  logic [7:0] rom_data = 8'd0;
  logic [3:0] display_signal;
  logic       busy;
  logic       done;
  logic [7:0] row_idx;

  logic [7:0] rom [256];

  int n_cmp  = 0;
  int n_err  = 0;
  int onsets = 0;
  int base   = 0;
  logic [3:0] prev_disp = 4'd0;

  chart_sequencer #(.ROW_AW(8)) dut (
    .Clk            (Clk),
    .reset_n        (reset_n),
    .frame_clk      (frame_clk),
    .start          (start),
    .stop           (stop),
    .frames_per_row (frames_per_row),
    .rom_addr       (rom_addr),
    .rom_data       (rom_data),
    .display_signal (display_signal),
    .busy           (busy),
    .done           (done),
    .row_idx        (row_idx)
  );

  always #5 Clk = ~Clk;

  // Synchronous chart ROM, 1-cycle read latency.
  always @(posedge Clk) rom_data <= rom[rom_addr];

  // Counts 0 -> nonzero transitions of display_signal (new arrow bursts).
  always @(negedge Clk) begin
    if (display_signal != 4'd0 && prev_disp == 4'd0) onsets <= onsets + 1;
    prev_disp <= display_signal;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One frame: rise seen on the next posedge, then 5 more cycles of settle.
  task automatic pulse_frame();
    @(negedge Clk) frame_clk = 1'b1;
    @(negedge Clk) frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
  endtask

  task automatic pulse_start(input logic [7:0] p);
    @(negedge Clk) begin start = 1'b1; frames_per_row = p; end
    @(negedge Clk) start = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  task automatic pulse_stop();
    @(negedge Clk) stop = 1'b1;
    @(negedge Clk) stop = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask

  initial begin
    clear_rom();

    // ---------------- reset values ----------------
    repeat (2) @(negedge Clk);
    check("rst_disp", display_signal, 4'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_addr", rom_addr, 8'h00);
    check("rst_row_idx", row_idx, 8'h00);
    @(negedge Clk) reset_n = 1'b1;
    repeat (2) @(negedge Clk);

    // ---------------- T1: basic chart, P=2 ----------------
    rom[0] = 8'h01; rom[1] = 8'h02; rom[2] = 8'h00; rom[3] = 8'h08; rom[4] = 8'h10;
    base = onsets;
    pulse_start(8'd2);
    check("t1_busy", busy, 1'b1);
    pulse_frame(); check("t1_r1_disp", display_signal, 4'h0);
    pulse_frame(); check("t1_r2_disp", display_signal, 4'h1);
    check("t1_r2_row", row_idx, 8'd0);
    pulse_frame(); check("t1_r3_disp", display_signal, 4'h0);
    pulse_frame(); check("t1_r4_disp", display_signal, 4'h2);
    check("t1_r4_row", row_idx, 8'd1);
    pulse_frame(); check("t1_r5_disp", display_signal, 4'h0);
    pulse_frame(); check("t1_r6_disp", display_signal, 4'h0);
    check("t1_r6_row", row_idx, 8'd2);
    pulse_frame(); check("t1_r7_disp", display_signal, 4'h0);
    check("t1_r7_done", done, 1'b0);
    pulse_frame(); check("t1_r8_disp", display_signal, 4'h8);
    check("t1_r8_row", row_idx, 8'd3);
    check("t1_r8_done", done, 1'b1);
    check("t1_r8_busy", busy, 1'b0);
    check("t1_r8_addr", rom_addr, 8'd4);
    pulse_frame(); check("t1_r9_disp", display_signal, 4'h0);
    check("t1_r9_done", done, 1'b1);
    check("t1_onsets", onsets - base, 3);

    // ---------------- T2: frames_per_row = 0 -> P = 1 ----------------
    clear_rom();
    rom[0] = 8'h03; rom[1] = 8'h05; rom[2] = 8'h09; rom[3] = 8'h10;
    base = onsets;
    pulse_start(8'd0);
    check("t2_done_cleared", done, 1'b0);
    pulse_frame(); check("t2_r1_disp", display_signal, 4'h3);
    check("t2_r1_row", row_idx, 8'd0);
    pulse_frame(); check("t2_r2_disp", display_signal, 4'h5);
    pulse_frame(); check("t2_r3_disp", display_signal, 4'h9);
    check("t2_r3_done", done, 1'b1);
    pulse_frame(); check("t2_r4_disp", display_signal, 4'h0);
    check("t2_onsets", onsets - base, 1);

    // ---------------- T3: stop mid-WAIT, replay, restart ----------------
    clear_rom();
    rom[0] = 8'h04; rom[1] = 8'h01; rom[2] = 8'h02; rom[3] = 8'h08; rom[4] = 8'h10;
    pulse_start(8'd3);
    pulse_frame(); pulse_frame();
    check("t3_r2_disp", display_signal, 4'h0);
    pulse_frame(); check("t3_r3_disp", display_signal, 4'h4);
    pulse_stop();
    check("t3_stop_disp", display_signal, 4'h0);
    check("t3_stop_busy", busy, 1'b0);
    check("t3_stop_done", done, 1'b0);
    pulse_frame(); pulse_frame(); pulse_frame();
    check("t3_idle_disp", display_signal, 4'h0);
    check("t3_idle_busy", busy, 1'b0);
    pulse_start(8'd3);
    pulse_frame(); pulse_frame(); pulse_frame();
    check("t3_replay_disp", display_signal, 4'h4);
    check("t3_replay_row", row_idx, 8'd0);
    pulse_frame(); pulse_frame(); pulse_frame();
    check("t3_row1_disp", display_signal, 4'h1);
    check("t3_row1_row", row_idx, 8'd1);
    pulse_start(8'd1);
    check("t3_restart_disp", display_signal, 4'h0);
    check("t3_restart_row", row_idx, 8'd0);
    check("t3_restart_busy", busy, 1'b1);
    pulse_frame(); check("t3_rs_r1_disp", display_signal, 4'h4);
    pulse_frame(); check("t3_rs_r2_disp", display_signal, 4'h1);

    // ---------------- T4: async reset during FETCH ----------------
    @(negedge Clk) frame_clk = 1'b1;
    @(negedge Clk) frame_clk = 1'b0;
    check("t4_pre_disp", display_signal, 4'h2);
    check("t4_pre_row", row_idx, 8'd2);
    check("t4_pre_addr", rom_addr, 8'd3);
    #1 reset_n = 1'b0;
    #1;
    check("t4_rst_disp", display_signal, 4'h0);
    check("t4_rst_busy", busy, 1'b0);
    check("t4_rst_row", row_idx, 8'd0);
    check("t4_rst_addr", rom_addr, 8'd0);
    check("t4_rst_done", done, 1'b0);
    @(negedge Clk) reset_n = 1'b1;
    pulse_frame(); pulse_frame();
    check("t4_idle_disp", display_signal, 4'h0);
    check("t4_idle_busy", busy, 1'b0);

    // ---------------- T5: address wrap, no end marker, P=1 ----------------
    for (int i = 0; i < 256; i++) rom[i] = {4'h0, i[3:0] ^ 4'h5};
    pulse_start(8'd1);
    pulse_frame(); check("t5_r1_disp", display_signal, 4'h5);
    check("t5_r1_row", row_idx, 8'd0);
    for (int r = 2; r <= 256; r++) begin
      pulse_frame();
      if (r == 128) begin
        check("t5_r128_row", row_idx, 8'd127);
        check("t5_r128_disp", display_signal, 4'hA);
      end
    end
    check("t5_r256_disp", display_signal, 4'hA);
    check("t5_r256_row", row_idx, 8'hFF);
`ifdef CHART_LOOP_EN
    check("t5_r256_done", done, 1'b0);
    check("t5_r256_busy", busy, 1'b1);
    pulse_frame();
    check("t5_r257_disp", display_signal, 4'h5);
    check("t5_r257_row", row_idx, 8'd0);
    check("t5_r257_done", done, 1'b0);
`else
    check("t5_r256_done", done, 1'b1);
    check("t5_r256_busy", busy, 1'b0);
    pulse_frame();
    check("t5_r257_disp", display_signal, 4'h0);
    check("t5_r257_row", row_idx, 8'hFF);
    check("t5_r257_done", done, 1'b1);
`endif

    // ---------------- T6: start and stop together ----------------
    @(negedge Clk) begin start = 1'b1; stop = 1'b1; frames_per_row = 8'd1; end
    @(negedge Clk) begin start = 1'b0; stop = 1'b0; end
    check("t6_busy", busy, 1'b0);
    check("t6_done", done, 1'b0);
    check("t6_disp", display_signal, 4'h0);
    pulse_frame();
    check("t6_idle_disp", display_signal, 4'h0);
    check("t6_idle_busy", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
